// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding, BCD digit limits and BCD increment for stopwatch_ctrl
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } sw_state_t;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    // Limits are compared with >= so a corrupted digit still wraps back into BCD range.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.sec_ones >= SEC_ONES_MAX) begin
            n.sec_ones = '0;
            if (t.sec_tens >= SEC_TENS_MAX) begin
                n.sec_tens = '0;
                if (t.min_ones >= MIN_ONES_MAX) begin
                    n.min_ones = '0;
                    if (t.min_tens >= MIN_TENS_MAX) begin
                        n.min_tens = '0;
                    end else begin
                        n.min_tens = t.min_tens + 4'd1;
                    end
                end else begin
                    n.min_ones = t.min_ones + 4'd1;
                end
            end else begin
                n.sec_tens = t.sec_tens + 4'd1;
            end
        end else begin
            n.sec_ones = t.sec_ones + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer, level debouncer and press (falling-edge) pulse for one key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt tracks consecutive samples that disagree with the accepted level; any agreeing sample restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync0 <= key_n;
            sync1 <= sync0;
            press <= 1'b0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync1;
                cnt   <= '0;
                press <= ~sync1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss stopwatch with start/pause and reset keys; lap freeze under STOPWATCH_LAP_EN
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_reset_n,
`ifdef STOPWATCH_LAP_EN
    input  logic       key_lap_n,
    output logic       lap_active,
`endif
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [1:0] state,
    output logic       tick_1hz
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    logic               start_press;
    logic               reset_press;
    sw_state_t          state_q;
    sw_state_t          state_d;
    logic [PRESC_W-1:0] presc_q;
    bcd_time_t          time_q;
    bcd_time_t          disp;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .clk   (clk_50MHz),
        .rst   (rst),
        .key_n (key_start_n),
        .press (start_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_reset (
        .clk   (clk_50MHz),
        .rst   (rst),
        .key_n (key_reset_n),
        .press (reset_press)
    );

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (reset_press) begin
            state_d = ST_IDLE;
        end else if (start_press) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A second is only counted if it is not being discarded by a reset press in the same cycle.
    assign tick_1hz = (state_q == ST_RUN) && (presc_q == PRESC_MAX) && !reset_press;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (reset_press) begin
            presc_q <= '0;
        end else if (state_q == ST_RUN) begin
            presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            time_q <= '0;
        end else if (reset_press) begin
            time_q <= '0;
        end else if (tick_1hz) begin
            time_q <= bcd_inc(time_q);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic      lap_press;
    bcd_time_t lap_snap;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
        .clk   (clk_50MHz),
        .rst   (rst),
        .key_n (key_lap_n),
        .press (lap_press)
    );

    // The snapshot register keeps its last value after release; only lap_active gates its use.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            lap_active <= 1'b0;
            lap_snap   <= '0;
        end else if (reset_press) begin
            lap_active <= 1'b0;
        end else if (lap_press) begin
            if (lap_active) begin
                lap_active <= 1'b0;
            end else if (state_q == ST_RUN) begin
                lap_snap   <= time_q;
                lap_active <= 1'b1;
            end
        end
    end

    assign disp = lap_active ? lap_snap : time_q;
`else
    assign disp = time_q;
`endif

    assign state    = state_q;
    assign sec_ones = disp.sec_ones;
    assign sec_tens = disp.sec_tens;
    assign min_ones = disp.min_ones;
    assign min_tens = disp.min_tens;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000: input clock cycles per counted second.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles (10 ms at 50 MHz) required to accept a key level.
REQ-003 Port clk_50MHz  in  1: single clock; all state on rising edge.
REQ-004 Port rst  in  1: asynchronous, active-high reset.
REQ-005 Port key_start_n  in  1: raw start/pause key, active-low, asynchronous to clk_50MHz.
REQ-006 Port key_reset_n  in  1: raw reset key, active-low, asynchronous.
REQ-007 Port key_lap_n  in  1: raw lap key, active-low; present only with STOPWATCH_LAP_EN.
REQ-008 Ports sec_ones, sec_tens, min_ones, min_tens  out  4 each: BCD mm:ss display digits.
REQ-009 Port state  out  2: IDLE=00, RUN=01, PAUSE=10; 11 is never driven.
REQ-010 Port tick_1hz  out  1: one-cycle pulse on every counted second.
REQ-011 Port lap_active  out  1: lap freeze indicator; present only with STOPWATCH_LAP_EN.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer followed by a debouncer.
REQ-013 The debouncer SHALL adopt a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any mismatch restarts the count.
REQ-014 A 1->0 transition of a debounced level SHALL produce exactly one single-cycle press pulse; holding a key SHALL NOT repeat the pulse.
REQ-015 Start press SHALL move the FSM IDLE->RUN, RUN->PAUSE, PAUSE->RUN; the new state is visible the cycle after the press pulse.
REQ-016 Reset press SHALL force IDLE from any state, clear all four digits to 0, and clear the prescaler.
REQ-017 Reset press SHALL win over a start or lap press in the same cycle.
REQ-018 Prescaler (width clog2(CLK_HZ)) SHALL count only in RUN.
REQ-019 On reaching CLK_HZ-1 the prescaler SHALL wrap to 0 and assert tick_1hz for that one cycle.
REQ-020 In PAUSE the prescaler SHALL hold its value, so the partial second is preserved; in IDLE it SHALL hold 0.
REQ-021 tick_1hz SHALL increment the BCD time by one second, visible on the digits the next cycle.
REQ-022 Digit ranges: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5, with ripple carry.
REQ-023 59:59 plus one tick SHALL wrap to 00:00 and remain in RUN.
REQ-024 Digits SHALL never hold non-BCD values.

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, all digits 0, tick_1hz=0, prescaler 0, debounced levels 1 (released), synchronizer flops 1, debounce counters 0, and lap_active=0.
REQ-026 Deassertion of rst mid-press SHALL NOT generate a press pulse until a full 1->0 debounced transition occurs.

Configuration
REQ-027 Macro STOPWATCH_LAP_EN SHALL compile in the lap feature, including key_lap_n, lap_active and a 16-bit lap snapshot register.
REQ-028 With STOPWATCH_LAP_EN, a lap press in RUN with lap_active=0 SHALL capture the live digits into the snapshot register and set lap_active.
REQ-029 With STOPWATCH_LAP_EN, a lap press while lap_active=1 SHALL clear lap_active in any state.
REQ-030 With STOPWATCH_LAP_EN, a lap press in IDLE or PAUSE with lap_active=0 SHALL be ignored.
REQ-031 With STOPWATCH_LAP_EN, while lap_active=1 the digit outputs SHALL show the snapshot while live counting continues internally.
REQ-032 With STOPWATCH_LAP_EN, a reset press SHALL clear lap_active.
REQ-033 Without STOPWATCH_LAP_EN, the lap ports and logic SHALL be absent and the digits SHALL always show the live count.

Structure
REQ-034 Package stopwatch_pkg SHALL hold the state encoding constants (ST_IDLE, ST_RUN, ST_PAUSE) and the BCD digit-limit constants.
REQ-035 Synchronizer plus debouncer plus falling-edge detector SHALL be one sub-module, key_debounce, instantiated once per key.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-036 Start key low 4+ cycles -> one press pulse; state 00->01; tick_1hz every 10 cycles; digits read 00:03 after 30 RUN cycles.
REQ-037 Key bounce 0/1/0 every 2 cycles, then stable low -> no state change until 4 stable cycles, then exactly one transition.
REQ-038 Run to 59:59, one more tick -> 00:00, state stays 01.
REQ-039 Pause at prescaler=6, hold 100 cycles, resume -> next tick arrives 3 cycles after RUN re-entry; digits unchanged during PAUSE.
REQ-040 Start and reset press pulses in the same cycle from RUN -> state 00, digits 00:00; assert rst mid-run -> all outputs 0 immediately, asynchronously.
REQ-041 (LAP_EN) Lap press at 00:12, run 50 more cycles -> outputs hold 00:12; second lap press -> outputs show 00:17.
